audio_input: RTL

Captures the PDM bitstream from the Nexys4DDR on-board microphone and packs it into 16-bit words. It drives the microphone clock and writes each completed word into the DelayBuffer through its Port A pins (write side). It is the capture-side counterpart of the PDM playback path, which reads Port B and serializes bit 0 first. audio_input therefore packs the first received bit into bit 0, so a word written here plays back in the same bit order.

---
 rtl/audio_input.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/audio_input.sv
// audio_input: PDM microphone capture. Drives the mic clock, samples the
// data line once per M_CLK period (on the falling edge) and packs 16 bits
// per word, first received bit in bit 0, then writes the word to the
// DelayBuffer write port with a wrapping address.
module audio_input #(
    parameter int MEM_WIDTH = 16,
    parameter int MEM_DEPTH = 65536,
    parameter int CLK_DIV   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PDM_in,
    input  logic                 record_en,
    output logic                 M_CLK,
    output logic                 LR_sel,
    output logic [MEM_WIDTH-1:0] data_out,
    output logic                 write_en,
    output logic [15:0]          write_address,
    output logic                 wrapped
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam int BIT_W = $clog2(MEM_WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MEM_WIDTH - 1);
    localparam logic [15:0] ADDR_LAST = 16'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        WRITE
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 m_clk_q, m_clk_d;
    logic                 rec_meta_q, rec_s_q;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [MEM_WIDTH-1:0] shreg_q, shreg_d;
    logic [MEM_WIDTH-1:0] data_out_q, data_out_d;
    logic                 write_en_q, write_en_d;
    logic [15:0]          addr_q, addr_d;
    logic                 wrapped_q, wrapped_d;

    logic                 strobe;
    logic [MEM_WIDTH-1:0] shifted;

    // Sample point: M_CLK high and about to fall on this edge.
    assign strobe  = m_clk_q && (div_cnt_q == DIV_LAST);
    assign shifted = {PDM_in, shreg_q[MEM_WIDTH-1:1]};

    // Free-running microphone clock divider.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        m_clk_d   = m_clk_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            m_clk_d   = ~m_clk_q;
        end
    end

    // Capture FSM next-state and datapath.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        data_out_d = data_out_q;
        write_en_d = 1'b0;
        addr_d     = addr_q;
        wrapped_d  = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (strobe && rec_s_q) begin
                    shreg_d   = shifted;
                    bit_cnt_d = BIT_W'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                // A dropped request discards the partial word outright.
                if (!rec_s_q) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (strobe) begin
                    shreg_d = shifted;
                    if (bit_cnt_q == BIT_LAST) begin
                        data_out_d = shifted;
                        write_en_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = WRITE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d    = '0;
                    wrapped_d = 1'b1;
                end else begin
                    addr_d = addr_q + 16'd1;
                end
                state_d = rec_s_q ? CAPTURE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All state registers, including the record_en synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            m_clk_q    <= 1'b0;
            rec_meta_q <= 1'b0;
            rec_s_q    <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_out_q <= '0;
            write_en_q <= 1'b0;
            addr_q     <= '0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            m_clk_q    <= m_clk_d;
            rec_meta_q <= record_en;
            rec_s_q    <= rec_meta_q;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_out_q <= data_out_d;
            write_en_q <= write_en_d;
            addr_q     <= addr_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign M_CLK         = m_clk_q;
    assign LR_sel        = 1'b0;
    assign data_out      = data_out_q;
    assign write_en      = write_en_q;
    assign write_address = addr_q;
    assign wrapped       = wrapped_q;

endmodule
